// File: rtl/pio_bank_irq_if.sv
// Avalon-MM slave bus bundle for pio_bank_irq: word address, strobes, write data
// and registered read data.
interface pio_bank_irq_if #(
   parameter int DATA_W = 32
);
   logic [3:0]        avs_address;
   logic              avs_chipselect;
   logic              avs_read;
   logic              avs_write;
   logic [DATA_W-1:0] avs_writedata;
   logic [DATA_W-1:0] avs_readdata;

   modport master (
      output avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
      input  avs_readdata
   );

   modport slave (
      input  avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
      output avs_readdata
   );
endinterface

// File: rtl/pio_bank_irq.sv
// Avalon-MM PIO bank: N_OUT output registers, synchronised input port with edge capture,
// interrupt mask and level irq. Define PIO_DEBOUNCE_EN to add a per-bit debounce filter.
module pio_bank_irq #(
   parameter int              DATA_W    = 32,
   parameter int              IN_W      = 16,
   parameter int              N_OUT     = 4,
   parameter int              EDGE_MODE = 0,
   parameter logic [DATA_W-1:0] OUT_RST = '0,
   parameter int              DEB_CYC   = 50000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   pio_bank_irq_if.slave           avs,
   output logic                    irq,
   input  logic [IN_W-1:0]         in_port,
   output logic [N_OUT*DATA_W-1:0] out_port
);

   if (IN_W < 1 || IN_W > DATA_W || N_OUT < 1 || N_OUT > 12 || DEB_CYC < 1) begin : g_bad_param
      $error("pio_bank_irq: parameter out of range");
   end

   logic [IN_W-1:0]   sync1, sync2, filt, filt_d;
   logic [IN_W-1:0]   edge_det, edge_cap, irq_mask, w1c;
   logic [DATA_W-1:0] out_reg [N_OUT];
   logic [DATA_W-1:0] rd_mux;
   logic              wr_en, rd_en;

   assign wr_en = avs.avs_chipselect & avs.avs_write;
   assign rd_en = avs.avs_chipselect & avs.avs_read;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1  <= '0;
         sync2  <= '0;
         filt_d <= '0;
      end else begin
         sync1  <= in_port;
         sync2  <= sync1;
         filt_d <= filt;
      end
   end

`ifdef PIO_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYC + 1);
   logic [CW-1:0] deb_cnt [IN_W];

   // Counter runs only while the synced bit disagrees with filt; any return to agreement restarts it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt <= '0;
         for (int unsigned b = 0; b < IN_W; b++) deb_cnt[b] <= '0;
      end else begin
         for (int unsigned b = 0; b < IN_W; b++) begin
            if (sync2[b] == filt[b]) begin
               deb_cnt[b] <= '0;
            end else if (deb_cnt[b] == CW'(DEB_CYC - 1)) begin
               filt[b]    <= sync2[b];
               deb_cnt[b] <= '0;
            end else begin
               deb_cnt[b] <= deb_cnt[b] + 1'b1;
            end
         end
      end
   end
`else
   assign filt = sync2;
`endif

   always_comb begin
      case (EDGE_MODE)
         0:       edge_det = filt & ~filt_d;
         1:       edge_det = ~filt & filt_d;
         default: edge_det = filt ^ filt_d;
      endcase
   end

   assign w1c = (wr_en && avs.avs_address == 4'd1) ? avs.avs_writedata[IN_W-1:0] : '0;

   always_comb begin
      rd_mux = '0;
      case (avs.avs_address)
         4'd0: rd_mux[IN_W-1:0] = filt;
         4'd1: rd_mux[IN_W-1:0] = edge_cap;
         4'd2: rd_mux[IN_W-1:0] = irq_mask;
         default: begin
            for (int unsigned k = 0; k < N_OUT; k++)
               if (avs.avs_address == 4'(k + 4)) rd_mux = out_reg[k];
         end
      endcase
   end

   // Edge is OR-ed in after the clear so a coincident edge keeps the bit set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_cap         <= '0;
         irq_mask         <= '0;
         irq              <= 1'b0;
         avs.avs_readdata <= '0;
         for (int unsigned k = 0; k < N_OUT; k++) out_reg[k] <= OUT_RST;
      end else begin
         edge_cap         <= (edge_cap & ~w1c) | edge_det;
         irq              <= |(edge_cap & irq_mask);
         avs.avs_readdata <= rd_en ? rd_mux : '0;
         if (wr_en && avs.avs_address == 4'd2) irq_mask <= avs.avs_writedata[IN_W-1:0];
         for (int unsigned k = 0; k < N_OUT; k++)
            if (wr_en && avs.avs_address == 4'(k + 4)) out_reg[k] <= avs.avs_writedata;
      end
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_out
      assign out_port[k*DATA_W +: DATA_W] = out_reg[k];
   end

endmodule
